// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage sitting directly upstream of the instruction memory.
// It owns the PC, drives the memory byte address, waits MEM_WAIT cycles for
// the memory's delayed read data, then hands the captured word and its PC to
// decode through a valid/ready output register. Branch/jump redirects,
// end-of-program (all-zero word) detection and address faults are handled
// here.
//
// Parameters:
//   RESET_PC   PC value loaded on reset.
//   MEM_WAIT   cycles the address is held before read data is sampled (>= 0).
//   MEM_BYTES  instruction memory size in bytes (multiple of 4).
//
// Ports:
//   clk               in   1   rising-edge clock
//   rst_n             in   1   asynchronous active-low reset
//   imem_address      out  32  byte address to instruction memory (= PC)
//   imem_instruction  in   32  instruction word returned by memory
//   redirect_valid    in   1   branch/jump taken this cycle
//   redirect_target   in   32  new PC when redirect_valid=1
//   id_ready          in   1   decode accepts id_* this cycle
//   id_valid          out  1   id_* holds a valid instruction
//   id_instruction    out  32  fetched word
//   id_pc             out  32  address of id_instruction
//   id_pc_plus4       out  32  id_pc + 4 (mod 2^32)
//   halted            out  1   fetch stopped, sticky until reset
//   fault             out  1   misaligned / out-of-range PC, sticky until reset
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WAIT  = 2,
    parameter int          MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        halted,
    output logic        fault
);

    // Counter must be able to hold 0..MEM_WAIT; keep at least one bit.
    localparam int              CNT_W     = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [31:0]      LAST_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    // A PC is legal only if word aligned and the whole word lies in memory.
    // Any pc+4 wrap lands at a small address only after passing LAST_ADDR,
    // so the wrap is always caught here first.
    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr > LAST_ADDR);
    endfunction

    state_t           state_r, state_s;
    logic [31:0]      pc_r, pc_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             id_valid_r, id_valid_s;
    logic [31:0]      id_instruction_r, id_instruction_s;
    logic [31:0]      id_pc_r, id_pc_s;
    logic [31:0]      id_pc_plus4_r, id_pc_plus4_s;
    logic             halted_r, halted_s;
    logic             fault_r, fault_s;

    logic             consume_s;
    logic             slot_free_s;

    // Handshake helpers: the pending word leaves when decode is ready, and
    // the output slot can take a new word when empty or being drained.
    always_comb begin
        consume_s   = id_valid_r & id_ready;
        slot_free_s = (~id_valid_r) | id_ready;
    end

    // Next-state logic: redirect > address check > wait > capture/backpressure.
    always_comb begin
        state_s          = state_r;
        pc_s             = pc_r;
        cnt_s            = cnt_r;
        id_valid_s       = id_valid_r;
        id_instruction_s = id_instruction_r;
        id_pc_s          = id_pc_r;
        id_pc_plus4_s    = id_pc_plus4_r;
        halted_s         = halted_r;
        fault_s          = fault_r;

        case (state_r)
            ST_FETCH: begin
                if (redirect_valid) begin
                    // Flush pending word; target gets checked next cycle.
                    pc_s       = redirect_target;
                    cnt_s      = CNT_ZERO;
                    id_valid_s = 1'b0;
                end else if ((cnt_r == CNT_ZERO) && addr_bad(pc_r)) begin
                    fault_s  = 1'b1;
                    halted_s = 1'b1;
                    state_s  = ST_HALT;
                    if (consume_s) begin
                        id_valid_s = 1'b0;
                    end else begin
                        id_valid_s = id_valid_r;
                    end
                end else if (cnt_r != WAIT_MAX) begin
                    cnt_s = cnt_r + CNT_ONE;
                    if (consume_s) begin
                        id_valid_s = 1'b0;
                    end else begin
                        id_valid_s = id_valid_r;
                    end
                end else if (slot_free_s) begin
                    if (imem_instruction == 32'h0000_0000) begin
                        // End of program: the zero word is never presented.
                        // Slot is free, so it is empty or being drained now.
                        halted_s   = 1'b1;
                        state_s    = ST_HALT;
                        id_valid_s = 1'b0;
                    end else begin
                        id_instruction_s = imem_instruction;
                        id_pc_s          = pc_r;
                        id_pc_plus4_s    = pc_r + 32'd4;
                        id_valid_s       = 1'b1;
                        pc_s             = pc_r + 32'd4;
                        cnt_s            = CNT_ZERO;
                    end
                end else begin
                    // Backpressure: counter saturated, everything holds.
                    cnt_s = WAIT_MAX;
                end
            end

            ST_HALT: begin
                // Frozen except that decode may still drain the last word.
                if (consume_s) begin
                    id_valid_s = 1'b0;
                end else begin
                    id_valid_s = id_valid_r;
                end
            end

            default: begin
                // Unreachable encoding: stop fetching safely.
                state_s    = ST_HALT;
                halted_s   = 1'b1;
                id_valid_s = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_FETCH;
            pc_r             <= RESET_PC;
            cnt_r            <= CNT_ZERO;
            id_valid_r       <= 1'b0;
            id_instruction_r <= 32'h0000_0000;
            id_pc_r          <= 32'h0000_0000;
            id_pc_plus4_r    <= 32'h0000_0000;
            halted_r         <= 1'b0;
            fault_r          <= 1'b0;
        end else begin
            state_r          <= state_s;
            pc_r             <= pc_s;
            cnt_r            <= cnt_s;
            id_valid_r       <= id_valid_s;
            id_instruction_r <= id_instruction_s;
            id_pc_r          <= id_pc_s;
            id_pc_plus4_r    <= id_pc_plus4_s;
            halted_r         <= halted_s;
            fault_r          <= fault_s;
        end
    end

    // All outputs come straight from registers.
    assign imem_address   = pc_r;
    assign id_valid       = id_valid_r;
    assign id_instruction = id_instruction_r;
    assign id_pc          = id_pc_r;
    assign id_pc_plus4    = id_pc_plus4_r;
    assign halted         = halted_r;
    assign fault          = fault_r;

endmodule
